// File: rtl/lsu_dcache.sv
// lsu_dcache: direct-mapped write-through, no-write-allocate data cache answering LSU requests.
// Define LSU_DCACHE_MMIO_BYPASS_EN to send addresses below 0x8000_0000 straight to memory.
module lsu_dcache #(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [1:0]        req_size,
    output logic              cache_rvalid,
    output logic [63:0]       cache_rdata,
    input  logic              resp_ready,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [1:0]        mem_req_len,
    output logic [63:0]       mem_req_wdata,
    output logic [7:0]        mem_req_wstrb,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_bvalid
);
    localparam int WI  = $clog2(LINE_WORDS);
    localparam int WIW = (WI > 0) ? WI : 1;
    localparam int SI  = $clog2(SETS);
    localparam int TL  = 3 + WI + SI;
    localparam int TW  = ADDR_W - TL;
    localparam int NW  = SETS * LINE_WORDS;
    localparam int AW  = $clog2(NW);

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, WR_REQ, WR_ACK, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, bypass_q, bypass_d;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic [1:0]        size_q;
    logic [WIW-1:0]    beat_q, beat_d;
    logic [63:0]       rdata_q, rdata_d;
    logic [SETS-1:0]   valid_q;
    logic [TW-1:0]     tag_q [SETS];
    logic [63:0]       data_q [NW];

    logic [2:0]     off;
    logic [5:0]     sh;
    logic [SI-1:0]  set_idx;
    logic [WIW-1:0] widx;
    logic [TW-1:0]  tag;
    logic [AW-1:0]  rd_idx, rf_idx;
    logic           hit, refill_last;
    logic [7:0]     strb;
    logic [63:0]    lane, merged;

`ifdef LSU_DCACHE_MMIO_BYPASS_EN
    assign bypass_d = req_addr < ADDR_W'(64'h8000_0000);
`else
    assign bypass_d = 1'b0;
`endif

    always_comb begin
        // sub-size offset bits are dropped: only naturally aligned accesses exist
        off         = addr_q[2:0] & ~3'((1 << size_q) - 1);
        sh          = {off, 3'b000};
        set_idx     = addr_q[3+WI +: SI];
        widx        = WIW'(addr_q[ADDR_W-1:3] & (ADDR_W-3)'(LINE_WORDS - 1));
        tag         = addr_q[ADDR_W-1:TL];
        rd_idx      = AW'(set_idx) * AW'(LINE_WORDS) + AW'(widx);
        rf_idx      = AW'(set_idx) * AW'(LINE_WORDS) + AW'(beat_q);
        hit         = valid_q[set_idx] && tag_q[set_idx] == tag;
        refill_last = state_q == REFILL && mem_rvalid && !bypass_q && beat_q == WIW'(LINE_WORDS - 1);
        strb        = (size_q == 2'd0 ? 8'h01 : size_q == 2'd1 ? 8'h03 : size_q == 2'd2 ? 8'h0F : 8'hFF) << off;
        lane        = wdata_q << sh;
        merged      = data_q[rd_idx];
        for (int b = 0; b < 8; b++)
            if (strb[b]) merged[8*b +: 8] = lane[8*b +: 8];
    end

    always_comb begin
        state_d = state_q;
        beat_d  = '0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE:     if (req_valid) state_d = LOOKUP;
            LOOKUP: begin
                state_d = we_q ? WR_REQ : (hit && !bypass_q) ? RESP : MISS_REQ;
                rdata_d = we_q ? 64'd0 : data_q[rd_idx] >> sh;
            end
            MISS_REQ: if (mem_req_ready) state_d = REFILL;
            REFILL: begin
                beat_d = beat_q;
                if (mem_rvalid) begin
                    beat_d = beat_q + 1'b1;
                    if (bypass_q || beat_q == widx) rdata_d = mem_rdata >> sh;
                    if (bypass_q || beat_q == WIW'(LINE_WORDS - 1)) state_d = RESP;
                end
            end
            WR_REQ:   if (mem_req_ready) state_d = WR_ACK;
            WR_ACK:   if (mem_bvalid) state_d = RESP;
            RESP:     if (resp_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign cache_rvalid  = state_q == RESP;
    assign cache_rdata   = rdata_q;
    assign mem_req_valid = state_q == MISS_REQ || state_q == WR_REQ;
    assign mem_req_we    = state_q == WR_REQ;
    assign mem_req_addr  = (state_q == WR_REQ || (state_q == MISS_REQ && bypass_q)) ? {addr_q[ADDR_W-1:3], 3'b000} :
                           state_q == MISS_REQ ? addr_q & ~ADDR_W'(8 * LINE_WORDS - 1) : '0;
    assign mem_req_len   = (state_q == MISS_REQ && !bypass_q) ? 2'(LINE_WORDS - 1) : 2'd0;
    assign mem_req_wdata = state_q == WR_REQ ? lane : 64'd0;
    assign mem_req_wstrb = state_q == WR_REQ ? strb : 8'd0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            rdata_q  <= '0;
            valid_q  <= '0;
            we_q     <= 1'b0;
            bypass_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            rdata_q <= rdata_d;
            if (state_q == IDLE && req_valid) begin
                we_q     <= req_we;
                bypass_q <= bypass_d;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                size_q   <= req_size;
            end
            if (refill_last) valid_q[set_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && state_q == LOOKUP && we_q && hit && !bypass_q) data_q[rd_idx] <= merged;
        if (rst && state_q == REFILL && mem_rvalid && !bypass_q) data_q[rf_idx] <= mem_rdata;
        if (rst && refill_last) tag_q[set_idx] <= tag;
    end
endmodule

// File: tb/tb_lsu_dcache.sv
// tb_lsu_dcache: directed checks of lsu_dcache with a hand-driven memory port.
module tb_lsu_dcache;
    logic        clk = 1'b0, rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        cache_rvalid;
    logic [63:0] cache_rdata;
    logic        resp_ready = 1'b1;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_we;
    logic [63:0] mem_req_addr;
    logic [1:0]  mem_req_len;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_rvalid = 1'b0, mem_bvalid = 1'b0;
    logic [63:0] mem_rdata = '0;
    int          total = 0, bad = 0;

    lsu_dcache dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .cache_rvalid(cache_rvalid),
        .cache_rdata(cache_rdata), .resp_ready(resp_ready), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_len(mem_req_len), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_bvalid(mem_bvalid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [63:0] addr, input logic [63:0] wd, input logic [1:0] size);
        req_we = we;
        req_addr = addr;
        req_wdata = wd;
        req_size = size;
        req_valid = 1'b1;
    endtask

    task automatic wait_memreq(input string tag);
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            tick;
            n++;
        end
        chk({tag, "_mreq"}, 64'(mem_req_valid), 64'd1);
    endtask

    task automatic finish_resp(input string tag);
        resp_ready = 1'b1;
        tick;
        req_valid = 1'b0;
        chk({tag, "_drop"}, 64'(cache_rvalid), 64'd0);
    endtask

    task automatic miss_load(input string tag, input logic [63:0] addr, input logic [63:0] line,
                             input int stall, input logic [63:0] d0, d1, d2, d3, input logic [63:0] exp);
        logic [63:0] d [4];
        d = '{d0, d1, d2, d3};
        issue(1'b0, addr, 64'd0, 2'd3);
        wait_memreq(tag);
        chk({tag, "_addr"}, mem_req_addr, line);
        chk({tag, "_len"}, 64'(mem_req_len), 64'd3);
        chk({tag, "_we"}, 64'(mem_req_we), 64'd0);
        for (int i = 0; i < stall; i++) begin
            tick;
            chk({tag, "_stall_v"}, 64'(mem_req_valid), 64'd1);
            chk({tag, "_stall_a"}, mem_req_addr, line);
            chk({tag, "_stall_l"}, 64'(mem_req_len), 64'd3);
        end
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_early"}, 64'(cache_rvalid), 64'd0);
            mem_rvalid = 1'b1;
            mem_rdata = d[i];
            tick;
        end
        mem_rvalid = 1'b0;
        chk({tag, "_rv"}, 64'(cache_rvalid), 64'd1);
        chk({tag, "_data"}, cache_rdata, exp);
        finish_resp(tag);
    endtask

    task automatic hit_load(input string tag, input logic [63:0] addr, input logic [1:0] size,
                            input logic [63:0] mask, input logic [63:0] exp, input int hold);
        resp_ready = (hold == 0);
        issue(1'b0, addr, 64'd0, size);
        tick;
        chk({tag, "_lat1"}, 64'(cache_rvalid), 64'd0);
        chk({tag, "_nomem1"}, 64'(mem_req_valid), 64'd0);
        tick;
        chk({tag, "_lat2"}, 64'(cache_rvalid), 64'd1);
        chk({tag, "_nomem2"}, 64'(mem_req_valid), 64'd0);
        chk({tag, "_data"}, cache_rdata & mask, exp);
        for (int i = 0; i < hold; i++) begin
            tick;
            chk({tag, "_hold_v"}, 64'(cache_rvalid), 64'd1);
            chk({tag, "_hold_d"}, cache_rdata & mask, exp);
        end
        finish_resp(tag);
    endtask

    task automatic store(input string tag, input logic [63:0] addr, input logic [63:0] wd, input logic [1:0] size,
                         input logic [63:0] eaddr, input logic [63:0] ewd, input logic [7:0] estrb);
        issue(1'b1, addr, wd, size);
        wait_memreq(tag);
        chk({tag, "_we"}, 64'(mem_req_we), 64'd1);
        chk({tag, "_addr"}, mem_req_addr, eaddr);
        chk({tag, "_len"}, 64'(mem_req_len), 64'd0);
        chk({tag, "_wdata"}, mem_req_wdata, ewd);
        chk({tag, "_wstrb"}, 64'(mem_req_wstrb), 64'(estrb));
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        chk({tag, "_onewrite"}, 64'(mem_req_valid), 64'd0);
        tick;
        chk({tag, "_waitack"}, 64'(cache_rvalid), 64'd0);
        mem_bvalid = 1'b1;
        tick;
        mem_bvalid = 1'b0;
        chk({tag, "_rv"}, 64'(cache_rvalid), 64'd1);
        chk({tag, "_rdata"}, cache_rdata, 64'd0);
        finish_resp(tag);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_rvalid", 64'(cache_rvalid), 64'd0);
        chk("rst_rdata", cache_rdata, 64'd0);
        chk("rst_mvalid", 64'(mem_req_valid), 64'd0);
        chk("rst_mwe", 64'(mem_req_we), 64'd0);
        chk("rst_maddr", mem_req_addr, 64'd0);
        chk("rst_mlen", 64'(mem_req_len), 64'd0);
        chk("rst_mwdata", mem_req_wdata, 64'd0);
        chk("rst_mwstrb", 64'(mem_req_wstrb), 64'd0);
        rst = 1'b1;
        tick;

        miss_load("cold", 64'h8000_0010, 64'h8000_0000, 3, 64'h0F0E0D0C0B0A0908, 64'h1716151413121110,
                  64'h1122334455667788, 64'h3736353433323130, 64'h1122334455667788);
        hit_load("hit_bp", 64'h8000_0010, 2'd3, '1, 64'h1122334455667788, 5);
        hit_load("lb", 64'h8000_0013, 2'd0, 64'hFF, 64'h55, 0);
        hit_load("lh", 64'h8000_0016, 2'd1, 64'hFFFF, 64'h1122, 0);
        hit_load("ld_w0", 64'h8000_0000, 2'd3, '1, 64'h0F0E0D0C0B0A0908, 0);

        store("sw_hit", 64'h8000_0014, 64'hDEAD_BEEF, 2'd2, 64'h8000_0010, 64'hDEADBEEF_00000000, 8'hF0);
        hit_load("ld_after_sw", 64'h8000_0010, 2'd3, '1, 64'hDEADBEEF55667788, 0);

        store("sd_miss", 64'h8001_0000, 64'hCAFEF00D12345678, 2'd3, 64'h8001_0000, 64'hCAFEF00D12345678, 8'hFF);
        miss_load("ld_after_sd", 64'h8001_0000, 64'h8001_0000, 0, 64'hE0E0E0E0E0E0E0E0, 64'hE1E1E1E1E1E1E1E1,
                  64'hE2E2E2E2E2E2E2E2, 64'hE3E3E3E3E3E3E3E3, 64'hE0E0E0E0E0E0E0E0);
        hit_load("conflict_hit", 64'h8001_0008, 2'd3, '1, 64'hE1E1E1E1E1E1E1E1, 0);

        issue(1'b0, 64'h8000_0020, 64'd0, 2'd3);
        wait_memreq("rstmid");
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata = 64'hBAD0 + 64'(i);
            tick;
        end
        rst = 1'b0;
        req_valid = 1'b0;
        mem_rdata = 64'hBAD2;
        tick;
        rst = 1'b1;
        mem_rdata = 64'hBAD3;
        tick;
        mem_rvalid = 1'b0;
        chk("rstmid_rvalid", 64'(cache_rvalid), 64'd0);
        chk("rstmid_mvalid", 64'(mem_req_valid), 64'd0);
        miss_load("rstmid_reload", 64'h8000_0020, 64'h8000_0020, 0, 64'hF0F0F0F0F0F0F0F0, 64'hF1F1F1F1F1F1F1F1,
                  64'hF2F2F2F2F2F2F2F2, 64'hF3F3F3F3F3F3F3F3, 64'hF0F0F0F0F0F0F0F0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_dcache.md
Name: lsu_dcache

Overview:
- Data-side responder for the LSU memory request port. The LSU is the initiator; this block is the responder at the other end of that port.
- Direct-mapped, write-through, no-write-allocate data cache.
- Returns load data right-aligned (addressed byte at bit 0), so the LSU's sign/zero-extension mux can consume it directly.
- Refills lines from a burst memory port. Acknowledges stores only after memory acknowledges the write.

Parameters:
- SETS, 64, number of lines; power of 2, minimum 2.
- LINE_WORDS, 4, 64-bit words per line; power of 2; also the refill burst length.
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- req_valid  in  1  LSU request valid; held with all req_* fields stable until response completes
- req_we  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  64  store data, right-aligned
- req_size  in  2  0=byte, 1=half, 2=word, 3=double
- cache_rvalid  out  1  response valid (load data or store done)
- cache_rdata  out  64  load data, right-aligned; upper bits beyond size are don't-care
- resp_ready  in  1  LSU/WB can take the response (wb_allowin)
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  write request
- mem_req_addr  out  ADDR_W  line-aligned for refill; word-aligned for write
- mem_req_len  out  2  beats-1 (LINE_WORDS-1 for refill, 0 for write)
- mem_req_wdata  out  64  store data, lane-aligned
- mem_req_wstrb  out  8  byte strobes
- mem_rvalid  in  1  refill beat valid
- mem_rdata  in  64  refill beat data
- mem_bvalid  in  1  write acknowledged

Behaviour:
- Reset (rst=0 at a clk edge):
  - all valid bits cleared; state=IDLE.
  - cache_rvalid=0, cache_rdata=0, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_len=0, mem_req_wdata=0, mem_req_wstrb=0.
  - Reset mid-refill or mid-write abandons the transfer. Memory beats arriving afterwards are ignored while in IDLE.
- Address split: offset[2:0], word index log2(LINE_WORDS), set index log2(SETS), remaining upper bits = tag. Low bits below the size alignment are ignored (aligned accesses only).
- FSM: IDLE, LOOKUP, MISS_REQ, REFILL, WR_REQ, WR_ACK, RESP.
- IDLE:
  - req_valid=1 → latch request; go to LOOKUP.
  - A new request is never accepted in the same cycle as a response completes.
- LOOKUP: hit = valid[set] && tag match.
  - Load hit → RESP. cache_rvalid rises 2 cycles after acceptance (hit latency 2).
  - Load miss → MISS_REQ.
  - Store (hit or miss) → WR_REQ. On hit, the line bytes selected by the strobes are updated in this cycle.
- MISS_REQ:
  - mem_req_valid=1, we=0, addr=line base, len=LINE_WORDS-1.
  - Go to REFILL on mem_req_ready.
- REFILL:
  - Each mem_rvalid writes the next word (beat counter 0..LINE_WORDS-1, wraps to 0).
  - After the last beat: tag written, valid set, go to RESP.
  - Response data comes from the refilled line (the beat captured for the requested word).
- WR_REQ:
  - mem_req_valid=1, we=1, addr=req_addr with [2:0] cleared, len=0.
  - wdata = req_wdata shifted left by 8*offset.
  - wstrb = ((1<<(1<<size))-1) << offset.
  - Go to WR_ACK on mem_req_ready.
- WR_ACK: wait for mem_bvalid → RESP. Store misses do not allocate.
- RESP:
  - cache_rvalid=1.
  - Loads: cache_rdata = selected word >> (8*offset). Stores: cache_rdata=0.
  - cache_rvalid and cache_rdata are held stable while resp_ready=0.
  - On cache_rvalid && resp_ready → IDLE; cache_rvalid drops the next cycle.
- mem_req_* fields are held stable while mem_req_valid=1 && mem_req_ready=0.
- mem_rvalid and mem_bvalid outside REFILL/WR_ACK are ignored.
- Set conflict: a refill overwrites the existing line unconditionally. Write-through, so no writeback is needed.

Optional Feature:
- Macro: LSU_DCACHE_MMIO_BYPASS_EN.
- Defined:
  - Addresses with req_addr < 64'h8000_0000 bypass the cache, with no lookup and no valid/tag change.
  - Loads issue a single-beat read (len=0, word-aligned addr). The beat is returned via RESP, shifted as above.
  - Stores follow WR_REQ/WR_ACK without touching the array.
  - Covers CLINT/UART regions if the LSU routes them here.
- Undefined: all addresses are cacheable.

Test Plan:
- Cold load ld 0x8000_0010 → MISS_REQ with addr 0x8000_0000, len 3. Beats D0..D3 returned. → cache_rvalid with rdata=D2. Repeat same load → hit, rvalid exactly 2 cycles after acceptance, no mem_req_valid.
- Byte load lb 0x8000_0013 after line holds D2=64'h1122334455667788 → rdata[7:0]=8'h55. lh 0x8000_0016 → rdata[15:0]=16'h1122.
- Store sw 0x8000_0014 data 0xDEADBEEF on hit → mem wstrb=8'hF0, wdata[63:32]=0xDEADBEEF. rvalid only after mem_bvalid. Following ld 0x8000_0010 → 64'hDEADBEEF55667788 with no refill.
- Store miss sd 0x8001_0000 → one memory write, no refill. Following ld to the same address → miss and refill.
- Backpressure: resp_ready=0 for 5 cycles during RESP → rvalid/rdata stable, no new acceptance. mem_req_ready=0 for 3 cycles → mem_req_* stable.
- Reset during beat 2 of a refill → line stays invalid. Next load to the same line re-issues the refill and ignores stale beats.
